// File: rtl/cpc_sync_shaper.sv
`default_nettype none
// ============================================================================
//  Module      : cpc_sync_shaper
//  Description : Shapes raw CRTC HSYNC/VSYNC into delayed, width-limited,
//                active-low monitor syncs (gate-array style) and blanks the
//                palette RGB outside display enable and during sync pulses.
//                All logic runs on the 16 MHz pixel clock.
//  Revision    : 1.0 - initial release
// ============================================================================
module cpc_sync_shaper #(
    parameter int HS_DELAY       = 32,
    parameter int HS_WIDTH       = 64,
    parameter int VS_DELAY_LINES = 2,
    parameter int VS_WIDTH_LINES = 4,
    parameter int COLOR_W        = 6
) (
    input  logic               clk_in,
    input  logic               reset_n,
    input  logic               crtc_hs,
    input  logic               crtc_vs,
    input  logic               crtc_de,
    input  logic [COLOR_W-1:0] r_in,
    input  logic [COLOR_W-1:0] g_in,
    input  logic [COLOR_W-1:0] b_in,
    output logic               hs_out,
    output logic               vs_out,
    output logic [COLOR_W-1:0] r_out,
    output logic [COLOR_W-1:0] g_out,
    output logic [COLOR_W-1:0] b_out
);

    // Counter widths: the pixel counter is never narrower than 8 bits.
    localparam int c_hmax    = (HS_DELAY > HS_WIDTH) ? HS_DELAY : HS_WIDTH;
    localparam int c_hcnt_w  = ($clog2(c_hmax + 1) > 8) ? $clog2(c_hmax + 1) : 8;
    localparam int c_lmax    = (VS_DELAY_LINES > VS_WIDTH_LINES) ? VS_DELAY_LINES : VS_WIDTH_LINES;
    localparam int c_lcnt_w  = ($clog2(c_lmax + 1) > 1) ? $clog2(c_lmax + 1) : 1;

    // Terminal counts; a zero line delay never reaches the DELAY state,
    // so its terminal value is clamped only to keep the constant legal.
    localparam logic [c_hcnt_w-1:0] c_hs_delay_last = c_hcnt_w'(HS_DELAY - 1);
    localparam logic [c_hcnt_w-1:0] c_hs_width_last = c_hcnt_w'(HS_WIDTH - 1);
    localparam logic [c_lcnt_w-1:0] c_vs_delay_last =
        c_lcnt_w'((VS_DELAY_LINES > 0) ? (VS_DELAY_LINES - 1) : 0);
    localparam logic [c_lcnt_w-1:0] c_vs_width_last = c_lcnt_w'(VS_WIDTH_LINES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DELAY = 2'd1,
        ST_PULSE = 2'd2
    } state_t;

    state_t              r_h_state, w_h_state_nxt;
    state_t              r_v_state, w_v_state_nxt;
    logic [c_hcnt_w-1:0] r_hcnt, w_hcnt_nxt;
    logic [c_lcnt_w-1:0] r_lcnt, w_lcnt_nxt;
    logic                r_hs_out, w_hs_out_nxt;
    logic                r_vs_out, w_vs_out_nxt;
    logic                r_hs_d, r_vs_d;
    logic                w_hs_rise, w_vs_rise;
    logic                w_blank;
    logic [COLOR_W-1:0]  r_red, r_grn, r_blu;

    // Previous-sample registers reset high so a level already high at
    // reset release is not mistaken for a rising edge.
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            r_hs_d <= 1'b1;
            r_vs_d <= 1'b1;
        end else begin
            r_hs_d <= crtc_hs;
            r_vs_d <= crtc_vs;
        end
    end

    assign w_hs_rise = crtc_hs & ~r_hs_d;
    assign w_vs_rise = crtc_vs & ~r_vs_d;

    // Horizontal FSM state, pixel counter and shaped hsync registers.
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            r_h_state <= ST_IDLE;
            r_hcnt    <= '0;
            r_hs_out  <= 1'b1;
        end else begin
            r_h_state <= w_h_state_nxt;
            r_hcnt    <= w_hcnt_nxt;
            r_hs_out  <= w_hs_out_nxt;
        end
    end

    // Horizontal next state: wait HS_DELAY clocks, then pulse until crtc_hs
    // drops or the width limit is reached.
    always_comb begin
        w_h_state_nxt = r_h_state;
        w_hcnt_nxt    = r_hcnt;
        w_hs_out_nxt  = r_hs_out;
        case (r_h_state)
            ST_IDLE: begin
                if (w_hs_rise) begin
                    w_h_state_nxt = ST_DELAY;
                    w_hcnt_nxt    = '0;
                end
            end
            ST_DELAY: begin
                if (!crtc_hs) begin
                    w_h_state_nxt = ST_IDLE;
                end else if (r_hcnt == c_hs_delay_last) begin
                    w_h_state_nxt = ST_PULSE;
                    w_hs_out_nxt  = 1'b0;
                    w_hcnt_nxt    = '0;
                end else begin
                    w_hcnt_nxt = r_hcnt + 1'b1;
                end
            end
            ST_PULSE: begin
                if (!crtc_hs || (r_hcnt == c_hs_width_last)) begin
                    w_h_state_nxt = ST_IDLE;
                    w_hs_out_nxt  = 1'b1;
                end else begin
                    w_hcnt_nxt = r_hcnt + 1'b1;
                end
            end
            default: begin
                w_h_state_nxt = ST_IDLE;
                w_hcnt_nxt    = '0;
                w_hs_out_nxt  = 1'b1;
            end
        endcase
    end

    // Vertical FSM state, line counter and shaped vsync registers.
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            r_v_state <= ST_IDLE;
            r_lcnt    <= '0;
            r_vs_out  <= 1'b1;
        end else begin
            r_v_state <= w_v_state_nxt;
            r_lcnt    <= w_lcnt_nxt;
            r_vs_out  <= w_vs_out_nxt;
        end
    end

    // Vertical next state: delay and width are counted in crtc_hs rises.
    // An hs rise coinciding with the vs rise is seen in IDLE and not counted.
    always_comb begin
        w_v_state_nxt = r_v_state;
        w_lcnt_nxt    = r_lcnt;
        w_vs_out_nxt  = r_vs_out;
        case (r_v_state)
            ST_IDLE: begin
                if (w_vs_rise) begin
                    w_lcnt_nxt = '0;
                    if (VS_DELAY_LINES == 0) begin
                        w_v_state_nxt = ST_PULSE;
                        w_vs_out_nxt  = 1'b0;
                    end else begin
                        w_v_state_nxt = ST_DELAY;
                    end
                end
            end
            ST_DELAY: begin
                if (!crtc_vs) begin
                    w_v_state_nxt = ST_IDLE;
                end else if (w_hs_rise) begin
                    if (r_lcnt == c_vs_delay_last) begin
                        w_v_state_nxt = ST_PULSE;
                        w_vs_out_nxt  = 1'b0;
                        w_lcnt_nxt    = '0;
                    end else begin
                        w_lcnt_nxt = r_lcnt + 1'b1;
                    end
                end
            end
            ST_PULSE: begin
                // Fixed width: crtc_vs falling here has no effect.
                if (w_hs_rise) begin
                    if (r_lcnt == c_vs_width_last) begin
                        w_v_state_nxt = ST_IDLE;
                        w_vs_out_nxt  = 1'b1;
                    end else begin
                        w_lcnt_nxt = r_lcnt + 1'b1;
                    end
                end
            end
            default: begin
                w_v_state_nxt = ST_IDLE;
                w_lcnt_nxt    = '0;
                w_vs_out_nxt  = 1'b1;
            end
        endcase
    end

    // Blank against the next-state syncs so colour stays aligned with them.
    assign w_blank = ~crtc_de | ~w_hs_out_nxt | ~w_vs_out_nxt;

    // Registered, blanked colour output (one clock latency).
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            r_red <= '0;
            r_grn <= '0;
            r_blu <= '0;
        end else if (w_blank) begin
            r_red <= '0;
            r_grn <= '0;
            r_blu <= '0;
        end else begin
            r_red <= r_in;
            r_grn <= g_in;
            r_blu <= b_in;
        end
    end

    assign hs_out = r_hs_out;
    assign vs_out = r_vs_out;
    assign r_out  = r_red;
    assign g_out  = r_grn;
    assign b_out  = r_blu;

endmodule
`default_nettype wire

// File: tb/tb_cpc_sync_shaper.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_cpc_sync_shaper
//  Description : Self-checking bench for cpc_sync_shaper with directed sync
//                scenarios, reset cases and randomised video lines compared
//                against a behavioural reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cpc_sync_shaper;

    localparam int HS_DELAY = 32;
    localparam int HS_WIDTH = 64;
    localparam int VS_DL    = 2;
    localparam int VS_WL    = 4;
    localparam int CW       = 6;

    logic          clk_in = 1'b0;
    logic          reset_n;
    logic          crtc_hs, crtc_vs, crtc_de;
    logic [CW-1:0] r_in, g_in, b_in;
    logic          hs_out, vs_out;
    logic [CW-1:0] r_out, g_out, b_out;

    cpc_sync_shaper #(
        .HS_DELAY       (HS_DELAY),
        .HS_WIDTH       (HS_WIDTH),
        .VS_DELAY_LINES (VS_DL),
        .VS_WIDTH_LINES (VS_WL),
        .COLOR_W        (CW)
    ) dut (
        .clk_in  (clk_in),
        .reset_n (reset_n),
        .crtc_hs (crtc_hs),
        .crtc_vs (crtc_vs),
        .crtc_de (crtc_de),
        .r_in    (r_in),
        .g_in    (g_in),
        .b_in    (b_in),
        .hs_out  (hs_out),
        .vs_out  (vs_out),
        .r_out   (r_out),
        .g_out   (g_out),
        .b_out   (b_out)
    );

    always #5 clk_in = ~clk_in;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: time-stamped hs rise and a per-frame line tally.
    int            cyc = 0;
    int            h_rise_cyc = 0;
    bit            h_valid = 1'b0;
    bit            m_hs_prev = 1'b1, m_vs_prev = 1'b1;
    bit            v_busy = 1'b0;
    int            v_lines = 0;
    logic          exp_hs = 1'b1, exp_vs = 1'b1;
    logic [3*CW-1:0] exp_rgb = '0;

    task automatic check_bit(input string tag, input logic obs, input logic expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, expv);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Advance the model by one clock using the inputs the DUT just sampled.
    task automatic model_update();
        bit hsr, vsr;
        int dt;
        cyc++;
        if (!reset_n) begin
            m_hs_prev = 1'b1;
            m_vs_prev = 1'b1;
            h_valid   = 1'b0;
            v_busy    = 1'b0;
            v_lines   = 0;
            exp_hs    = 1'b1;
            exp_vs    = 1'b1;
            exp_rgb   = '0;
            return;
        end
        hsr = crtc_hs && !m_hs_prev;
        vsr = crtc_vs && !m_vs_prev;
        // hsync: low for clocks HS_DELAY .. HS_DELAY+HS_WIDTH-1 after the rise,
        // but only while crtc_hs has stayed high since that rise.
        if (hsr) begin
            h_valid    = 1'b1;
            h_rise_cyc = cyc;
        end
        dt = cyc - h_rise_cyc;
        exp_hs = !(h_valid && crtc_hs && dt >= HS_DELAY && dt < HS_DELAY + HS_WIDTH);
        // vsync: counts hs rises after an accepted vs rise; low between the
        // VS_DL-th and (VS_DL+VS_WL)-th; cancelled if vs drops during the delay.
        if (!v_busy) begin
            if (vsr) begin
                v_busy  = 1'b1;
                v_lines = 0;
            end
        end else if (v_lines < VS_DL && !crtc_vs) begin
            v_busy = 1'b0;
        end else if (hsr) begin
            v_lines++;
            if (v_lines == VS_DL + VS_WL) v_busy = 1'b0;
        end
        exp_vs = !(v_busy && v_lines >= VS_DL);
        exp_rgb = (crtc_de && exp_hs && exp_vs) ? {r_in, g_in, b_in} : '0;
        m_hs_prev = crtc_hs;
        m_vs_prev = crtc_vs;
    endtask

    // One clock: inputs are already set; sample outputs 1 ns after the edge.
    task automatic step();
        @(posedge clk_in);
        #1;
        model_update();
        check_bit("hs_out", hs_out, exp_hs);
        check_bit("vs_out", vs_out, exp_vs);
        n_checks++;
        assert ({r_out, g_out, b_out} === exp_rgb) else begin
            n_fail++;
            $error("FAIL rgb_out cyc=%0d observed=%h expected=%h", cyc, {r_out, g_out, b_out}, exp_rgb);
        end
    endtask

    task automatic rand_rgb();
        r_in = CW'($urandom);
        g_in = CW'($urandom);
        b_in = CW'($urandom);
    endtask

    // Hold crtc_hs high for n clocks; index 0 is the rise edge.
    task automatic run_hs(input int n, output int first_low, output int last_low, output int low_cnt);
        first_low = -1;
        last_low  = -1;
        low_cnt   = 0;
        crtc_hs   = 1'b1;
        for (int i = 0; i < n; i++) begin
            crtc_de = 1'b1;
            rand_rgb();
            step();
            if (hs_out === 1'b0) begin
                if (first_low < 0) first_low = i;
                last_low = i;
                low_cnt++;
            end
        end
        crtc_hs = 1'b0;
        for (int i = 0; i < 20; i++) step();
    endtask

    int fl, ll, lc;
    int vs_fall, vs_back, vs_low_cnt;
    bit prev_vs;

    initial begin
        reset_n = 1'b0;
        crtc_hs = 1'b0;
        crtc_vs = 1'b0;
        crtc_de = 1'b0;
        r_in = '0; g_in = '0; b_in = '0;

        // Reset state
        for (int i = 0; i < 3; i++) step();
        check_bit("reset_hs", hs_out, 1'b1);
        check_bit("reset_vs", vs_out, 1'b1);
        check_int("reset_rgb", int'({r_out, g_out, b_out}), 0);
        reset_n = 1'b1;
        for (int i = 0; i < 10; i++) step();

        // Long hsync: limited to HS_WIDTH
        run_hs(100, fl, ll, lc);
        check_int("t1_first_low", fl, 32);
        check_int("t1_last_low", ll, 95);
        check_int("t1_low_cnt", lc, 64);

        // Hsync ending mid-pulse
        run_hs(50, fl, ll, lc);
        check_int("t2_first_low", fl, 32);
        check_int("t2_last_low", ll, 49);

        // Hsync shorter than the delay, then an immediate retrigger
        run_hs(20, fl, ll, lc);
        check_int("t3_low_cnt", lc, 0);
        run_hs(40, fl, ll, lc);
        check_int("t3_retrigger", fl, 32);

        // Blanking with fixed colours
        crtc_de = 1'b1;
        r_in = 6'h2A; g_in = 6'h15; b_in = 6'h3F;
        step();
        check_int("t5_rgb_pass", int'({r_out, g_out, b_out}), int'({6'h2A, 6'h15, 6'h3F}));
        crtc_de = 1'b0;
        step();
        check_int("t5_rgb_de0", int'({r_out, g_out, b_out}), 0);

        // Vertical sync: 1024-clock lines, vs rises mid-line
        vs_fall = -1; vs_back = -1; prev_vs = 1'b1;
        for (int ln = 0; ln < 9; ln++) begin
            for (int i = 0; i < 1024; i++) begin
                crtc_hs = (i < 100);
                if (ln == 0 && i == 500) crtc_vs = 1'b1;
                if (ln == 3 && i == 300) crtc_vs = 1'b0;
                crtc_de = (i >= 200);
                rand_rgb();
                step();
                if (vs_out === 1'b0 && prev_vs) vs_fall = ln * 1024 + i;
                if (vs_out === 1'b1 && !prev_vs) vs_back = ln * 1024 + i;
                prev_vs = vs_out;
            end
        end
        check_int("t4_vs_fall", vs_fall, 2 * 1024);
        check_int("t4_vs_back", vs_back, 6 * 1024);

        // Vertical sync cancelled by crtc_vs dropping after one line
        vs_low_cnt = 0;
        for (int ln = 0; ln < 4; ln++) begin
            for (int i = 0; i < 1024; i++) begin
                crtc_hs = (i < 100);
                if (ln == 0 && i == 500) crtc_vs = 1'b1;
                if (ln == 1 && i == 300) crtc_vs = 1'b0;
                step();
                if (vs_out === 1'b0) vs_low_cnt++;
            end
        end
        check_int("t4_cancel", vs_low_cnt, 0);
        crtc_hs = 1'b0;
        for (int i = 0; i < 10; i++) step();

        // Asynchronous reset in the middle of an hsync pulse
        crtc_hs = 1'b1;
        crtc_de = 1'b1;
        for (int i = 0; i < 40; i++) begin
            rand_rgb();
            step();
        end
        check_bit("t6_in_pulse", hs_out, 1'b0);
        #2 reset_n = 1'b0;
        #1;
        check_bit("t6_async_hs", hs_out, 1'b1);
        check_bit("t6_async_vs", vs_out, 1'b1);
        check_int("t6_async_rgb", int'({r_out, g_out, b_out}), 0);
        for (int i = 0; i < 3; i++) step();
        reset_n = 1'b1;
        lc = 0;
        for (int i = 0; i < 60; i++) begin
            rand_rgb();
            step();
            if (hs_out === 1'b0) lc++;
        end
        check_int("t6_no_pulse", lc, 0);
        crtc_hs = 1'b0;
        for (int i = 0; i < 5; i++) step();
        run_hs(80, fl, ll, lc);
        check_int("t6_next_pulse", fl, 32);

        // Randomised lines with random vsync toggles, de and colours
        for (int ln = 0; ln < 60; ln++) begin
            int len, hs_st, hs_len, vs_at;
            len    = $urandom_range(400, 150);
            hs_st  = $urandom_range(20, 0);
            hs_len = $urandom_range(120, 1);
            vs_at  = ($urandom_range(3, 0) == 0) ? $urandom_range(len - 1, 0) : -1;
            for (int i = 0; i < len; i++) begin
                crtc_hs = (i >= hs_st) && (i < hs_st + hs_len);
                if (i == vs_at) crtc_vs = ~crtc_vs;
                crtc_de = ($urandom_range(3, 0) != 0);
                rand_rgb();
                step();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
